arbiter_iwrr_prog: RTL

Parametrised interleaved weighted round-robin arbiter for the interconnect's AR/AW/W channel muxes. Weights are programmable at run time and a mode input selects plain round-robin or IWRR. Each grant is charged a variable beat cost, and the block reports round completion. It sits in front of each slave-port mux and drives the one-hot select, plus an encoded index for the data-path mux.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/arb_rr_picker.sv | 57 +++++
 rtl/arbiter_iwrr_prog.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared mode encodings and a saturating-subtract helper for
//                the programmable IWRR arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam logic ARB_MODE_RR   = 1'b0;
    localparam logic ARB_MODE_IWRR = 1'b1;

    // Working width of the helper; callers truncate back to their counter width.
    localparam int ARB_SAT_W = 16;

    // a - b, clamped at zero so a credit counter can never wrap.
    function automatic logic [ARB_SAT_W-1:0] arb_sat_sub(
        input logic [ARB_SAT_W-1:0] a,
        input logic [ARB_SAT_W-1:0] b
    );
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : arb_rr_picker
//  Description : Combinational circular find-first. Returns the first set
//                candidate at or after ptr, wrapping past the top index.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_picker
    import arb_pkg::*;
#(
    parameter int P_REQUESTER_NUM = 4,
    parameter int P_IDX_W         = $clog2(P_REQUESTER_NUM)
)(
    input  logic [P_REQUESTER_NUM-1:0] cand,
    input  logic [P_IDX_W-1:0]         ptr,
    output logic [P_REQUESTER_NUM-1:0] onehot,
    output logic [P_IDX_W-1:0]         idx,
    output logic                       any_valid
);

    localparam int C_DBL_W = 2 * P_REQUESTER_NUM;

    logic [C_DBL_W-1:0] therm;
    logic [C_DBL_W-1:0] dbl;

    // Thermometer mask keeping every doubled position at or above ptr.
    always_comb begin
        therm = '0;
        for (int j = 0; j < C_DBL_W; j++) begin
            therm[j] = (j >= int'(ptr));
        end
    end

    // The upper copy supplies the wrapped-around candidates below ptr.
    assign dbl       = {cand, cand} & therm;
    assign any_valid = |cand;

    // Lowest surviving doubled position, folded back into requester space.
    always_comb begin
        idx = '0;
        for (int j = C_DBL_W - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                idx = P_IDX_W'(j % P_REQUESTER_NUM);
            end
        end
    end

    // One-hot view of the chosen index.
    always_comb begin
        onehot = '0;
        if (any_valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbiter_iwrr_prog.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_iwrr_prog
//  Description : Interleaved weighted round-robin arbiter with run-time
//                programmable weights, per-grant beat cost, plain-RR mode
//                and a registered round-completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbiter_iwrr_prog
    import arb_pkg::*;
#(
    parameter int                              P_REQUESTER_NUM  = 4,
    parameter int                              P_WEIGHT_W       = 4,
    parameter logic [32*P_REQUESTER_NUM-1:0]   P_DEFAULT_WEIGHT = {32'd5, 32'd3, 32'd2, 32'd1},
    parameter int                              P_COST_W         = 3,
    parameter int                              P_IDX_W          = $clog2(P_REQUESTER_NUM)
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [P_REQUESTER_NUM-1:0] req_i,
    input  logic [P_COST_W-1:0]        cost_i,
    input  logic                       grant_ready_i,
    input  logic                       mode_i,
    input  logic                       cfg_wr_en_i,
    input  logic [P_IDX_W-1:0]         cfg_idx_i,
    input  logic [P_WEIGHT_W-1:0]      cfg_weight_i,
    output logic [P_REQUESTER_NUM-1:0] grant_valid_o,
    output logic [P_IDX_W-1:0]         grant_idx_o,
    output logic                       round_done_o
);

    localparam logic [P_IDX_W-1:0] C_LAST_IDX = P_IDX_W'(P_REQUESTER_NUM - 1);

    logic [P_WEIGHT_W-1:0]      dflt       [P_REQUESTER_NUM];
    logic [P_WEIGHT_W-1:0]      weight_r   [P_REQUESTER_NUM];
    logic [P_WEIGHT_W-1:0]      cnt        [P_REQUESTER_NUM];
    logic [P_WEIGHT_W-1:0]      cnt_nxt    [P_REQUESTER_NUM];
    logic [P_IDX_W-1:0]         ptr;
    logic [P_IDX_W-1:0]         ptr_nxt;
    logic                       round_done_r;
    logic                       round_done_nxt;

    logic [P_REQUESTER_NUM-1:0] unmasked;
    logic [P_REQUESTER_NUM-1:0] has_credit;
    logic [P_REQUESTER_NUM-1:0] live_req;
    logic [P_REQUESTER_NUM-1:0] elig;
    logic [P_REQUESTER_NUM-1:0] cand;
    logic [P_REQUESTER_NUM-1:0] pick_onehot;
    logic [P_IDX_W-1:0]         pick_idx;
    logic                       pick_any;
    logic                       iwrr;
    logic                       refill;
    logic                       accept;
    logic                       any_left;
    logic [P_COST_W-1:0]        eff_cost;
    logic [P_WEIGHT_W-1:0]      grant_base;
    logic [P_WEIGHT_W-1:0]      charged;

    // Entry 0 of the default-weight vector sits at the MSB end.
    for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_dflt
        assign dflt[i] = P_DEFAULT_WEIGHT[(P_REQUESTER_NUM-1-i)*32 +: P_WEIGHT_W];
    end

    // A zero weight masks the requester at once, independent of its counter.
    for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_flags
        assign unmasked[i]   = (weight_r[i] != '0);
        assign has_credit[i] = (cnt[i] != '0);
    end

    assign iwrr     = (mode_i == ARB_MODE_IWRR);
    assign live_req = req_i & unmasked;
    assign elig     = iwrr ? (live_req & has_credit) : live_req;
    // Everyone still asking is out of credit: pick as if counters were reloaded.
    assign refill   = iwrr & (|live_req) & ~(|elig);
    assign cand     = refill ? live_req : elig;

    arb_rr_picker #(
        .P_REQUESTER_NUM (P_REQUESTER_NUM),
        .P_IDX_W         (P_IDX_W)
    ) u_picker (
        .cand      (cand),
        .ptr       (ptr),
        .onehot    (pick_onehot),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    assign grant_valid_o = pick_onehot;
    assign grant_idx_o   = pick_any ? pick_idx : '0;
    assign round_done_o  = round_done_r;
    assign accept        = pick_any & grant_ready_i;

    // A zero cost still consumes one credit.
    assign eff_cost   = (cost_i == '0) ? P_COST_W'(1) : cost_i;
    assign grant_base = refill ? weight_r[pick_idx] : cnt[pick_idx];
    assign charged    = P_WEIGHT_W'(arb_sat_sub(ARB_SAT_W'(grant_base), ARB_SAT_W'(eff_cost)));

    // Next pointer, credit counters and round-done pulse for an accepted grant.
    always_comb begin
        ptr_nxt        = ptr;
        round_done_nxt = 1'b0;
        any_left       = 1'b0;
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        if (accept) begin
            ptr_nxt = (pick_idx == C_LAST_IDX) ? '0 : pick_idx + P_IDX_W'(1);
            if (iwrr) begin
                for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                    cnt_nxt[i] = refill ? weight_r[i] : cnt[i];
                end
                cnt_nxt[pick_idx] = charged;
                for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                    if ((weight_r[i] != '0) && (cnt_nxt[i] != '0)) begin
                        any_left = 1'b1;
                    end
                end
                // Natural end of round: reload from the weights as they stood this cycle.
                if (!any_left) begin
                    for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                        cnt_nxt[i] = weight_r[i];
                    end
                end
                round_done_nxt = refill | ~any_left;
            end else begin
                round_done_nxt = (pick_idx == C_LAST_IDX);
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            round_done_r <= 1'b0;
            for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                cnt[i] <= dflt[i];
            end
        end else begin
            ptr          <= ptr_nxt;
            round_done_r <= round_done_nxt;
            for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Weight table: written any cycle, out-of-range indices dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                weight_r[i] <= dflt[i];
            end
        end else if (cfg_wr_en_i && (int'(cfg_idx_i) < P_REQUESTER_NUM)) begin
            weight_r[cfg_idx_i] <= cfg_weight_i;
        end
    end

endmodule
`default_nettype wire
